// File: rtl/pipeline_sequencer_pkg.sv
// pipe_seq_pkg: shared types and default sizes for the pipeline sequencer.
//   seq_state_t      : sequencer FSM states
//   REG_AW_DEF       : default register-file address width
//   DRAIN_CYCLES_DEF : default cycles to retire execute/memory/writeback
//   CNT_W_DEF        : default performance counter width
package pipe_seq_pkg;

  localparam int REG_AW_DEF       = 4;
  localparam int DRAIN_CYCLES_DEF = 3;
  localparam int CNT_W_DEF        = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    STEP   = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } seq_state_t;

endpackage

// File: rtl/pipeline_sequencer_if.sv
// pipeline_sequencer_if: bundle between the sequencer and the CPU datapath.
//   Inputs to the sequencer : start, step_mode, step_req, dec_* hazard fields,
//                             ex_* execute-stage fields, wb_valid
//   Outputs of the sequencer: PC/pipeline-register controls, running/halted,
//                             cycle_count, retire_count
//   modport master : the sequencer side
//   modport slave  : the CPU / switch side
interface pipeline_sequencer_if
  import pipe_seq_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = CNT_W_DEF
);

  logic              start;
  logic              step_mode;
  logic              step_req;
  logic              dec_halt;
  logic [REG_AW-1:0] dec_rs1;
  logic [REG_AW-1:0] dec_rs2;
  logic              dec_use_rs1;
  logic              dec_use_rs2;
  logic              ex_is_load;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_branch_taken;
  logic              wb_valid;

  logic              pc_we;
  logic              pc_sel_branch;
  logic              pc_clear;
  logic              fd_we;
  logic              fd_flush;
  logic              de_flush;
  logic              running;
  logic              halted;
  logic [CNT_W-1:0]  cycle_count;
  logic [CNT_W-1:0]  retire_count;

  modport master (
    input  start, step_mode, step_req, dec_halt, dec_rs1, dec_rs2,
           dec_use_rs1, dec_use_rs2, ex_is_load, ex_rd, ex_branch_taken, wb_valid,
    output pc_we, pc_sel_branch, pc_clear, fd_we, fd_flush, de_flush,
           running, halted, cycle_count, retire_count
  );

  modport slave (
    output start, step_mode, step_req, dec_halt, dec_rs1, dec_rs2,
           dec_use_rs1, dec_use_rs2, ex_is_load, ex_rd, ex_branch_taken, wb_valid,
    input  pc_we, pc_sel_branch, pc_clear, fd_we, fd_flush, de_flush,
           running, halted, cycle_count, retire_count
  );

endinterface

// File: rtl/pipeline_sequencer_hazard_detect.sv
// hazard_detect: combinational load-use comparator.
//   ex_is_load_i, ex_rd_i        : execute-stage load and its destination
//   dec_rs1_i/dec_rs2_i          : decode-stage source registers
//   dec_use_rs1_i/dec_use_rs2_i  : which decode sources are actually read
//   load_use_o                   : decode needs a value the load has not produced yet
module hazard_detect
  import pipe_seq_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              ex_is_load_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic [REG_AW-1:0] dec_rs1_i,
  input  logic [REG_AW-1:0] dec_rs2_i,
  input  logic              dec_use_rs1_i,
  input  logic              dec_use_rs2_i,
  output logic              load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = dec_use_rs1_i && (dec_rs1_i == ex_rd_i);
  assign rs2_hit = dec_use_rs2_i && (dec_rs2_i == ex_rd_i);

  // r0 is hard-wired zero, so a load into it never creates a dependency.
  assign load_use_o = ex_is_load_i && (ex_rd_i != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: run/stall/flush controller for the 5-stage CPU.
//   clk   : core clock
//   reset : asynchronous, active-low reset
//   bus   : pipeline_sequencer_if.master (run controls, hazard inputs,
//           PC / pipeline-register controls, status and counters)
// Optional feature macro: PIPE_SEQ_PERF_EN builds cycle_count/retire_count;
// without it both outputs read as 0 and no counter flops exist.
module pipeline_sequencer
  import pipe_seq_pkg::*;
#(
  parameter int REG_AW       = REG_AW_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_sequencer_if.master  bus
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  seq_state_t    state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          start_q;
  logic          armed_q;
  logic          start_rise;
  logic          load_use;
  logic          adv;
  logic          halt_go;
  logic          count_cycle;
  logic          restart;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .ex_is_load_i  (bus.ex_is_load),
    .ex_rd_i       (bus.ex_rd),
    .dec_rs1_i     (bus.dec_rs1),
    .dec_rs2_i     (bus.dec_rs2),
    .dec_use_rs1_i (bus.dec_use_rs1),
    .dec_use_rs2_i (bus.dec_use_rs2),
    .load_use_o    (load_use)
  );

  // armed_q blocks a false edge when the start switch is already high as
  // reset releases: the switch must be seen low before a rise counts.
  assign start_rise = bus.start && !start_q && armed_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      drain_q <= '0;
      start_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      start_q <= bus.start;
      armed_q <= armed_q || !bus.start;
    end
  end

  always_comb begin
    state_d           = state_q;
    drain_d           = drain_q;
    bus.pc_we         = 1'b0;
    bus.pc_sel_branch = 1'b0;
    bus.pc_clear      = 1'b0;
    bus.fd_we         = 1'b0;
    bus.fd_flush      = 1'b0;
    bus.de_flush      = 1'b0;
    adv               = 1'b0;
    halt_go           = 1'b0;
    count_cycle       = 1'b0;
    restart           = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_rise) state_d = bus.step_mode ? STEP : RUN;
      end
      RUN, STEP: begin
        adv = (state_q == RUN) || bus.step_req;
        if (adv) begin
          count_cycle = 1'b1;
          if (bus.ex_branch_taken) begin
            // Decode and fetch hold wrong-path instructions; squash both.
            bus.pc_we         = 1'b1;
            bus.pc_sel_branch = 1'b1;
            bus.fd_flush      = 1'b1;
            bus.de_flush      = 1'b1;
          end else if (load_use) begin
            bus.de_flush = 1'b1;
          end else if (bus.dec_halt) begin
            bus.de_flush = 1'b1;
            halt_go      = 1'b1;
          end else begin
            bus.pc_we = 1'b1;
            bus.fd_we = 1'b1;
          end
        end
        if (halt_go) begin
          state_d = DRAIN;
          drain_d = DW'(DRAIN_CYCLES - 1);
        end else begin
          state_d = bus.step_mode ? STEP : RUN;
        end
      end
      DRAIN: begin
        bus.de_flush = 1'b1;
        count_cycle  = 1'b1;
        if (drain_q == '0) state_d = HALTED;
        else               drain_d = drain_q - DW'(1);
      end
      HALTED: begin
        if (start_rise) begin
          bus.pc_clear = 1'b1;
          bus.fd_flush = 1'b1;
          restart      = 1'b1;
          state_d      = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.running = (state_q == RUN) || (state_q == STEP);
  assign bus.halted  = (state_q == HALTED);

`ifdef PIPE_SEQ_PERF_EN
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ret_q, ret_d;

  always_comb begin
    cyc_d = cyc_q;
    ret_d = ret_q;
    if (restart) begin
      cyc_d = '0;
      ret_d = '0;
    end else begin
      if (count_cycle)                         cyc_d = cyc_q + CNT_W'(1);
      if (bus.wb_valid && (state_q != IDLE))   ret_d = ret_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ret_q <= ret_d;
    end
  end

  assign bus.cycle_count  = cyc_q;
  assign bus.retire_count = ret_q;
`else
  assign bus.cycle_count  = {CNT_W{1'b0}};
  assign bus.retire_count = {CNT_W{1'b0}};
  logic unused_perf;
  assign unused_perf = ^{count_cycle, restart, bus.wb_valid};
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer: table-driven hazard vectors, hand-written multi-cycle
// sequences and randomized stimulus, all cross-checked every cycle against a
// behavioural model of the sequencer rules.
module tb_pipeline_sequencer;

  localparam int RAW = 4;
  localparam int CW  = 32;
  localparam int DC  = 3;
`ifdef PIPE_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Model states (bench-local numbering).
  localparam int S_IDLE = 0, S_RUN = 1, S_STEP = 2, S_DRAIN = 3, S_HALTED = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pipeline_sequencer_if #(.REG_AW(RAW), .CNT_W(CW)) bus ();

  pipeline_sequencer #(.REG_AW(RAW), .CNT_W(CW), .DRAIN_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Control vector bits: pc_we, pc_sel_branch, pc_clear, fd_we, fd_flush,
  // de_flush, running, halted.
  logic [7:0] last_ctl;

  int          m_st;
  int          m_nxt;
  int          m_left;
  bit          m_prev_start;
  bit          m_restart;
  bit          m_cinc;
  logic [7:0]  m_exp;
  logic [CW-1:0] m_cyc;
  logic [CW-1:0] m_ret;

  typedef struct {
    logic           br;
    logic           ld;
    logic [RAW-1:0] rd;
    logic [RAW-1:0] rs1;
    logic [RAW-1:0] rs2;
    logic           u1;
    logic           u2;
    logic           halt;
    logic [7:0]     exp;
  } vec_t;

  vec_t vt[10];

  function automatic vec_t mk(logic br, logic ld, int rd, int rs1, int rs2,
                              logic u1, logic u2, logic halt, logic [7:0] exp);
    vec_t v;
    v.br = br; v.ld = ld; v.rd = RAW'(rd); v.rs1 = RAW'(rs1); v.rs2 = RAW'(rs2);
    v.u1 = u1; v.u2 = u2; v.halt = halt; v.exp = exp;
    return v;
  endfunction

  function automatic logic [7:0] ctl_now();
    return {bus.pc_we, bus.pc_sel_branch, bus.pc_clear, bus.fd_we,
            bus.fd_flush, bus.de_flush, bus.running, bus.halted};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_left = 0; m_cyc = '0; m_ret = '0;
    m_prev_start = 1'b1;  // a held switch must be seen low before it counts
  endtask

  task automatic model_eval();
    bit rise, lu;
    m_exp = 8'h00; m_nxt = m_st; m_restart = 0; m_cinc = 0;
    rise = bus.start && !m_prev_start;
    lu = bus.ex_is_load && (bus.ex_rd != 0) &&
         ((bus.dec_use_rs1 && bus.dec_rs1 == bus.ex_rd) ||
          (bus.dec_use_rs2 && bus.dec_rs2 == bus.ex_rd));
    case (m_st)
      S_IDLE: if (rise) m_nxt = bus.step_mode ? S_STEP : S_RUN;
      S_RUN, S_STEP: begin
        if (m_st == S_RUN || bus.step_req) begin
          m_cinc = 1;
          if (bus.ex_branch_taken)  m_exp[7:2] = 6'b110011;
          else if (lu)              m_exp[2] = 1'b1;
          else if (bus.dec_halt) begin
            m_exp[2] = 1'b1;
            m_nxt = S_DRAIN;
          end else                  m_exp[7:2] = 6'b100100;
        end
        if (m_nxt != S_DRAIN) m_nxt = bus.step_mode ? S_STEP : S_RUN;
      end
      S_DRAIN: begin
        m_exp[2] = 1'b1; m_cinc = 1;
        if (m_left == 1) m_nxt = S_HALTED;
      end
      S_HALTED: if (rise) begin
        m_exp[5] = 1'b1; m_exp[3] = 1'b1; m_nxt = S_RUN; m_restart = 1;
      end
      default: ;
    endcase
    m_exp[1] = (m_st == S_RUN) || (m_st == S_STEP);
    m_exp[0] = (m_st == S_HALTED);
  endtask

  task automatic model_commit();
    if (m_restart) begin
      m_cyc = '0; m_ret = '0;
    end else begin
      if (m_cinc) m_cyc = m_cyc + 1;
      if (bus.wb_valid && m_st != S_IDLE) m_ret = m_ret + 1;
    end
    if (m_nxt == S_DRAIN && m_st != S_DRAIN) m_left = DC;
    else if (m_st == S_DRAIN)                m_left = m_left - 1;
    m_st = m_nxt;
    m_prev_start = bus.start;
  endtask

  // One clock cycle: inputs already driven at posedge+1; sample at posedge+4.
  task automatic step_cycle(input string name, input bit use_want, input logic [7:0] want);
    model_eval();
    #3;
    last_ctl = ctl_now();
    chk("model_ctl", last_ctl, m_exp);
    chk("counters", {bus.cycle_count, bus.retire_count}, PERF ? {m_cyc, m_ret} : 64'd0);
    if (use_want) chk(name, last_ctl, want);
    @(posedge clk); #1;
    model_commit();
  endtask

  task automatic quiet();
    bus.step_req = 0; bus.dec_halt = 0; bus.dec_rs1 = '0; bus.dec_rs2 = '0;
    bus.dec_use_rs1 = 0; bus.dec_use_rs2 = 0; bus.ex_is_load = 0; bus.ex_rd = '0;
    bus.ex_branch_taken = 0; bus.wb_valid = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("reset_ctl", ctl_now(), 64'd0);
    chk("reset_cnt", {bus.cycle_count, bus.retire_count}, 64'd0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    int pulses;
    bus.start = 0; bus.step_mode = 0;
    quiet();

    vt[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 8'b1001_0010);  // nothing pending
    vt[1] = mk(0, 1, 3, 0, 3, 0, 1, 0, 8'b0000_0110);  // rs2 load-use
    vt[2] = mk(0, 1, 0, 0, 0, 0, 1, 0, 8'b1001_0010);  // load into r0
    vt[3] = mk(0, 1, 7, 7, 2, 1, 0, 0, 8'b0000_0110);  // rs1 load-use
    vt[4] = mk(0, 1, 7, 7, 2, 0, 0, 0, 8'b1001_0010);  // rs1 match, unused
    vt[5] = mk(0, 0, 3, 0, 3, 0, 1, 0, 8'b1001_0010);  // not a load
    vt[6] = mk(1, 1, 3, 0, 3, 0, 1, 1, 8'b1100_1110);  // branch beats stall+halt
    vt[7] = mk(1, 0, 0, 0, 0, 0, 0, 0, 8'b1100_1110);  // branch alone
    vt[8] = mk(0, 1, 3, 0, 2, 0, 1, 0, 8'b1001_0010);  // register mismatch
    vt[9] = mk(0, 1, 5, 5, 5, 1, 1, 0, 8'b0000_0110);  // both sources hit

    do_reset();
    step_cycle("idle", 1, 8'h00);
    bus.start = 1;
    step_cycle("start_rise", 1, 8'h00);
    step_cycle("run_first", 1, 8'b1001_0010);

    for (int i = 0; i < 10; i++) begin
      bus.ex_branch_taken = vt[i].br; bus.ex_is_load = vt[i].ld; bus.ex_rd = vt[i].rd;
      bus.dec_rs1 = vt[i].rs1; bus.dec_rs2 = vt[i].rs2; bus.dec_use_rs1 = vt[i].u1;
      bus.dec_use_rs2 = vt[i].u2; bus.dec_halt = vt[i].halt; bus.wb_valid = 1;
      step_cycle($sformatf("vec%0d", i), 1, vt[i].exp);
    end
    quiet();

    // Halt, drain, halted, restart.
    bus.dec_halt = 1;
    step_cycle("halt", 1, 8'b0000_0110);
    bus.dec_halt = 0;
    for (int i = 0; i < DC; i++) step_cycle("drain", 1, 8'b0000_0100);
    step_cycle("halted", 1, 8'b0000_0001);
    bus.start = 0;
    step_cycle("halted_low", 1, 8'b0000_0001);
    bus.start = 1; bus.wb_valid = 1;
    step_cycle("restart", 1, 8'b0010_1001);
    bus.wb_valid = 0;
    #2 chk("restart_cnt", {bus.cycle_count, bus.retire_count}, 64'd0);
    step_cycle("run_after_restart", 1, 8'b1001_0010);

    // Single-step: four pulses over twenty cycles.
    do_reset();
    bus.start = 0; bus.step_mode = 1;
    step_cycle("idle2", 1, 8'h00);
    bus.start = 1;
    step_cycle("start_step", 1, 8'h00);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      bus.step_req = (i % 5 == 2);
      step_cycle("step", 1, bus.step_req ? 8'b1001_0010 : 8'b0000_0010);
      pulses += int'(last_ctl[7]);
    end
    bus.step_req = 0;
    chk("step_pc_we_count", 64'(pulses), 64'd4);
    chk("step_cycle_count", 64'(bus.cycle_count), PERF ? 64'd4 : 64'd0);

    // Reset in the middle of DRAIN with start still held high.
    bus.step_mode = 0;
    step_cycle("step_to_run", 1, 8'b0000_0010);
    bus.dec_halt = 1;
    step_cycle("halt2", 1, 8'b0000_0110);
    bus.dec_halt = 0;
    step_cycle("drain2", 1, 8'b0000_0100);
    do_reset();
    for (int i = 0; i < 3; i++) step_cycle("held_start", 1, 8'h00);
    bus.start = 0;
    step_cycle("start_low", 1, 8'h00);
    bus.start = 1;
    step_cycle("rise_again", 1, 8'h00);
    step_cycle("run3", 1, 8'b1001_0010);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      if ($urandom_range(0, 9) == 0)  bus.start = ~bus.start;
      if ($urandom_range(0, 19) == 0) bus.step_mode = ~bus.step_mode;
      bus.step_req        = ($urandom_range(0, 9) < 3);
      bus.dec_halt        = ($urandom_range(0, 19) == 0);
      bus.ex_branch_taken = ($urandom_range(0, 6) == 0);
      bus.ex_is_load      = ($urandom_range(0, 9) < 4);
      bus.ex_rd           = RAW'($urandom_range(0, 3));
      bus.dec_rs1         = RAW'($urandom_range(0, 3));
      bus.dec_rs2         = RAW'($urandom_range(0, 3));
      bus.dec_use_rs1     = $urandom_range(0, 1) == 1;
      bus.dec_use_rs2     = $urandom_range(0, 1) == 1;
      bus.wb_valid        = $urandom_range(0, 1) == 1;
      step_cycle("rand", 0, 8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
